cdb_broadcaster: RTL and testbench

Producer end of the common data bus (CDB). Collects completed results from the add/sub and mul/div functional units and buffers them per unit. Arbitrates round-robin between the two buffers and broadcasts one {tag, value} per cycle. Reservation stations and the register status table snoop the broadcast; they are the receiving end of this bus.

---
 rtl/tomasulo_pkg.sv | 35 +++
 rtl/cdb_result_fifo.sv | 59 +++++
 rtl/cdb_broadcaster.sv | 135 +++++++++++++
 tb/tb_cdb_broadcaster.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo datapath: result and tag widths, the
// "no producer" tag, CDB source encoding and the reservation-station tag map.
// No ports (package).
// -----------------------------------------------------------------------------
package tomasulo_pkg;

   localparam int DATA_W   = 8;
   localparam int TAG_W    = 4;

   // Tag 0 never names a station; a Qj/Qk of 0 means the operand is ready.
   localparam int TAG_NONE = 0;

   // Which source buffer a broadcast came from.
   typedef enum logic {
      SRC_ADD = 1'b0,
      SRC_MUL = 1'b1
   } cdb_src_e;

   // Station tag map.
   localparam int ADD_TAG_LO = 1;
   localparam int ADD_TAG_HI = 3;
   localparam int MUL_TAG_LO = 4;
   localparam int MUL_TAG_HI = 6;

   function automatic logic is_add_station(input logic [TAG_W-1:0] tag);
      return (int'(tag) >= ADD_TAG_LO) && (int'(tag) <= ADD_TAG_HI);
   endfunction

   function automatic logic is_mul_station(input logic [TAG_W-1:0] tag);
      return (int'(tag) >= MUL_TAG_LO) && (int'(tag) <= MUL_TAG_HI);
   endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// -----------------------------------------------------------------------------
// cdb_result_fifo
// In-order result buffer for one functional unit. Push and pop may happen on
// the same edge. not_full is registered from the post-edge count, so a full
// buffer that pops on an edge still refuses a push on that same edge.
// Ports:
//   clock, resetn  : rising-edge clock, async active-low reset
//   push, push_data: write an entry (caller only pushes while not_full)
//   pop            : drop the head (caller only pops while count != 0)
//   head           : current head entry (valid when count != 0)
//   count          : number of stored entries, 0..DEPTH
//   not_full       : registered, count < DEPTH after the last edge
// -----------------------------------------------------------------------------
module cdb_result_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     not_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_next;

   assign count_next = count + CNT_W'(push) - CNT_W'(pop);
   assign head       = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by overflow.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         not_full <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         not_full <= (count_next < CNT_W'(DEPTH));
      end
   end

   // Storage carries no reset; entries are only read while count != 0.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
// Producer end of the common data bus. Buffers finished results from the
// add/sub and mul/div units, arbitrates round-robin between the two buffers
// and broadcasts one {tag, value} per cycle as a single-cycle pulse.
// Ports:
//   clock, resetn                     : rising-edge clock, async active-low reset
//   add_valid/add_tag/add_result      : add/sub result offer
//   add_ready                         : add/sub buffer accepts this cycle
//   mul_valid/mul_tag/mul_result      : mul/div result offer
//   mul_ready                         : mul/div buffer accepts this cycle
//   cdb_valid/cdb_tag/cdb_value       : broadcast strobe and payload
//   cdb_src                           : 0 = add/sub buffer, 1 = mul/div buffer
//   tag_err                           : sticky, a tag-0 result was accepted
//
// Handshake: a result transfers on a rising edge where valid && ready are both
// high; the unit holds valid, tag and result unchanged until that edge. ready
// is registered and never depends on valid in the same cycle. The bus itself
// has no backpressure.
// -----------------------------------------------------------------------------
module cdb_broadcaster #(
   parameter int DATA_W     = tomasulo_pkg::DATA_W,
   parameter int TAG_W      = tomasulo_pkg::TAG_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              add_valid,
   input  logic [TAG_W-1:0]  add_tag,
   input  logic [DATA_W-1:0] add_result,
   output logic              add_ready,
   input  logic              mul_valid,
   input  logic [TAG_W-1:0]  mul_tag,
   input  logic [DATA_W-1:0] mul_result,
   output logic              mul_ready,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_value,
   output logic              cdb_src,
   output logic              tag_err
);

   import tomasulo_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = TAG_W + DATA_W;

   logic             add_accept, mul_accept;
   logic             add_push, mul_push;
   logic             add_pop, mul_pop;
   logic [ENT_W-1:0] add_head, mul_head;
   logic [CNT_W-1:0] add_count, mul_count;
   logic             add_nonempty, mul_nonempty;
   logic             zero_tag_seen;
   cdb_src_e         last_src;

   assign add_accept = add_valid && add_ready;
   assign mul_accept = mul_valid && mul_ready;

   // A tag-0 result completes its handshake but is dropped: nothing waits on it.
   assign add_push = add_accept && (add_tag != TAG_W'(TAG_NONE));
   assign mul_push = mul_accept && (mul_tag != TAG_W'(TAG_NONE));

   assign zero_tag_seen = (add_accept && (add_tag == TAG_W'(TAG_NONE))) ||
                          (mul_accept && (mul_tag == TAG_W'(TAG_NONE)));

   cdb_result_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_add_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (add_push),
      .push_data ({add_tag, add_result}),
      .pop       (add_pop),
      .head      (add_head),
      .count     (add_count),
      .not_full  (add_ready)
   );

   cdb_result_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_mul_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (mul_push),
      .push_data ({mul_tag, mul_result}),
      .pop       (mul_pop),
      .head      (mul_head),
      .count     (mul_count),
      .not_full  (mul_ready)
   );

   assign add_nonempty = (add_count != '0);
   assign mul_nonempty = (mul_count != '0);

   // Arbitration on pre-edge buffer state; on a tie the source not granted
   // last wins, which bounds each source to one grant every two cycles.
   always_comb begin
      add_pop = 1'b0;
      mul_pop = 1'b0;
      if (add_nonempty && (!mul_nonempty || (last_src == SRC_MUL))) begin
         add_pop = 1'b1;
      end else if (mul_nonempty) begin
         mul_pop = 1'b1;
      end
   end

   // Output registers. Payload holds its last value when nothing is granted;
   // last_src starts at SRC_MUL so add wins the first tie.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= 1'b0;
         last_src  <= SRC_MUL;
         tag_err   <= 1'b0;
      end else begin
         cdb_valid <= add_pop || mul_pop;
         if (add_pop) begin
            {cdb_tag, cdb_value} <= add_head;
            cdb_src              <= SRC_ADD;
            last_src             <= SRC_ADD;
         end else if (mul_pop) begin
            {cdb_tag, cdb_value} <= mul_head;
            cdb_src              <= SRC_MUL;
            last_src             <= SRC_MUL;
         end
         if (zero_tag_seen) tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// tb_cdb_broadcaster
// Directed and random stimulus for cdb_broadcaster with a per-source expected
// queue. Each stimulus queue holds {tag, value} entries a unit still has to
// offer; accepted non-zero tags move to the expected queue of that source and
// every broadcast must match the head of the queue named by cdb_src.
// -----------------------------------------------------------------------------
module tb_cdb_broadcaster;

   localparam int DATA_W = 8;
   localparam int TAG_W  = 4;
   localparam int ENT_W  = TAG_W + DATA_W;

   logic              clock;
   logic              resetn;
   logic              add_valid;
   logic [TAG_W-1:0]  add_tag;
   logic [DATA_W-1:0] add_result;
   logic              add_ready;
   logic              mul_valid;
   logic [TAG_W-1:0]  mul_tag;
   logic [DATA_W-1:0] mul_result;
   logic              mul_ready;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_value;
   logic              cdb_src;
   logic              tag_err;

   logic [ENT_W-1:0] stim_add_q[$];
   logic [ENT_W-1:0] stim_mul_q[$];
   logic [ENT_W-1:0] exp_add_q[$];
   logic [ENT_W-1:0] exp_mul_q[$];

   int n_vec;
   int n_miss;

   cdb_broadcaster #(
      .DATA_W     (DATA_W),
      .TAG_W      (TAG_W),
      .FIFO_DEPTH (2)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .add_valid  (add_valid),
      .add_tag    (add_tag),
      .add_result (add_result),
      .add_ready  (add_ready),
      .mul_valid  (mul_valid),
      .mul_tag    (mul_tag),
      .mul_result (mul_result),
      .mul_ready  (mul_ready),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .cdb_src    (cdb_src),
      .tag_err    (tag_err)
   );

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      add_valid  = 1'b0;
      mul_valid  = 1'b0;
      add_tag    = '0;
      add_result = '0;
      mul_tag    = '0;
      mul_result = '0;
      stim_add_q.delete();
      stim_mul_q.delete();
      exp_add_q.delete();
      exp_mul_q.delete();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
      check("rst_cdb_tag",   32'(cdb_tag),   32'd0);
      check("rst_cdb_value", 32'(cdb_value), 32'd0);
      check("rst_cdb_src",   32'(cdb_src),   32'd0);
      check("rst_add_ready", 32'(add_ready), 32'd0);
      check("rst_mul_ready", 32'(mul_ready), 32'd0);
      check("rst_tag_err",   32'(tag_err),   32'd0);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      check("rel_add_ready", 32'(add_ready), 32'd1);
      check("rel_mul_ready", 32'(mul_ready), 32'd1);
      check("rel_cdb_valid", 32'(cdb_valid), 32'd0);
   endtask

   // One clock: present stimulus heads, record accepts, score the broadcast.
   task automatic step();
      logic             acc_add;
      logic             acc_mul;
      logic [ENT_W-1:0] ent;
      if (stim_add_q.size() != 0) begin
         add_valid = 1'b1;
         {add_tag, add_result} = stim_add_q[0];
      end else begin
         add_valid = 1'b0;
      end
      if (stim_mul_q.size() != 0) begin
         mul_valid = 1'b1;
         {mul_tag, mul_result} = stim_mul_q[0];
      end else begin
         mul_valid = 1'b0;
      end
      acc_add = add_valid && add_ready;
      acc_mul = mul_valid && mul_ready;
      @(posedge clock);
      #1;
      if (acc_add) begin
         ent = stim_add_q.pop_front();
         if (ent[ENT_W-1 -: TAG_W] != '0) exp_add_q.push_back(ent);
      end
      if (acc_mul) begin
         ent = stim_mul_q.pop_front();
         if (ent[ENT_W-1 -: TAG_W] != '0) exp_mul_q.push_back(ent);
      end
      if (cdb_valid) begin
         if (cdb_src == 1'b0) begin
            check("sb_add_pending", 32'(exp_add_q.size() != 0), 32'd1);
            if (exp_add_q.size() != 0) begin
               ent = exp_add_q.pop_front();
               check("sb_add_entry", 32'({cdb_tag, cdb_value}), 32'(ent));
            end
         end else begin
            check("sb_mul_pending", 32'(exp_mul_q.size() != 0), 32'd1);
            if (exp_mul_q.size() != 0) begin
               ent = exp_mul_q.pop_front();
               check("sb_mul_entry", 32'({cdb_tag, cdb_value}), 32'(ent));
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((stim_add_q.size() + stim_mul_q.size() + exp_add_q.size() + exp_mul_q.size() != 0)
             && (n < budget)) begin
         step();
         n++;
      end
      step();
      check("drain_stim_left", 32'(stim_add_q.size() + stim_mul_q.size()), 32'd0);
      check("drain_exp_left",  32'(exp_add_q.size() + exp_mul_q.size()), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      n_vec  = 0;
      n_miss = 0;
      resetn = 1'b0;

      // Single add result: broadcast one cycle after acceptance, one-cycle pulse.
      do_reset();
      stim_add_q.push_back({4'd1, 8'h06});
      step();
      check("single_not_yet",  32'(cdb_valid), 32'd0);
      step();
      check("single_valid",    32'(cdb_valid), 32'd1);
      check("single_tag",      32'(cdb_tag),   32'd1);
      check("single_value",    32'(cdb_value), 32'h06);
      check("single_src",      32'(cdb_src),   32'd0);
      step();
      check("single_pulse",    32'(cdb_valid), 32'd0);
      check("single_tag_hold", 32'(cdb_tag),   32'd1);

      // Simultaneous pairs: add wins the first tie from reset; after mul was
      // granted last, the next tie goes to add again.
      do_reset();
      stim_add_q.push_back({4'd2, 8'h05});
      stim_mul_q.push_back({4'd4, 8'h08});
      step();
      check("pair1_idle", 32'(cdb_valid), 32'd0);
      step();
      check("pair1_first_src", 32'(cdb_src), 32'd0);
      check("pair1_first_tag", 32'(cdb_tag), 32'd2);
      step();
      check("pair1_second_src", 32'(cdb_src),   32'd1);
      check("pair1_second_tag", 32'(cdb_tag),   32'd4);
      check("pair1_second_val", 32'(cdb_value), 32'h08);
      stim_add_q.push_back({4'd3, 8'h11});
      stim_mul_q.push_back({4'd5, 8'h22});
      step();
      check("pair2_idle", 32'(cdb_valid), 32'd0);
      step();
      check("pair2_first_src", 32'(cdb_src), 32'd0);
      step();
      check("pair2_second_src", 32'(cdb_src), 32'd1);
      check("pair2_second_tag", 32'(cdb_tag), 32'd5);

      // Fill: mul 4,5,6 against a streaming add source.
      do_reset();
      stim_mul_q.push_back({4'd4, 8'hA1});
      stim_mul_q.push_back({4'd5, 8'hA2});
      stim_mul_q.push_back({4'd6, 8'hA3});
      stim_add_q.push_back({4'd1, 8'hB1});
      stim_add_q.push_back({4'd2, 8'hB2});
      stim_add_q.push_back({4'd3, 8'hB3});
      stim_add_q.push_back({4'd1, 8'hB4});
      step();
      check("fill_mul_ready_1", 32'(mul_ready), 32'd1);
      step();
      check("fill_mul_ready_full", 32'(mul_ready), 32'd0);
      check("fill_first_tag",      32'(cdb_tag),   32'd1);
      step();
      check("fill_second_tag", 32'(cdb_tag),   32'd4);
      check("fill_add_full",   32'(add_ready), 32'd0);
      check("fill_mul_reopen", 32'(mul_ready), 32'd1);
      drain(30);

      // Tag 0: accepted, dropped, sticky error.
      stim_add_q.push_back({4'd0, 8'h77});
      step();
      check("tag0_accepted", 32'(stim_add_q.size()), 32'd0);
      check("tag0_err",      32'(tag_err),           32'd1);
      step();
      check("tag0_no_bcast1", 32'(cdb_valid), 32'd0);
      step();
      check("tag0_no_bcast2", 32'(cdb_valid), 32'd0);
      stim_add_q.push_back({4'd2, 8'h12});
      stim_mul_q.push_back({4'd6, 8'h34});
      drain(20);
      check("tag0_err_sticky", 32'(tag_err), 32'd1);

      // Asynchronous reset while both buffers hold entries and a broadcast is up.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         stim_add_q.push_back({4'(1 + i), 8'(8'hC0 + i)});
         stim_mul_q.push_back({4'(4 + i), 8'(8'hD0 + i)});
      end
      step();
      step();
      check("midrst_pre_valid", 32'(cdb_valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_valid",     32'(cdb_valid), 32'd0);
      check("midrst_tag",       32'(cdb_tag),   32'd0);
      check("midrst_value",     32'(cdb_value), 32'd0);
      check("midrst_add_ready", 32'(add_ready), 32'd0);
      check("midrst_mul_ready", 32'(mul_ready), 32'd0);
      stim_add_q.delete();
      stim_mul_q.delete();
      exp_add_q.delete();
      exp_mul_q.delete();
      add_valid = 1'b0;
      mul_valid = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("midrst_no_stale", 32'(cdb_valid), 32'd0);
      end

      // Random back-to-back traffic on both sources.
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         if ((stim_add_q.size() == 0) && ($urandom_range(0, 3) != 0))
            stim_add_q.push_back({4'($urandom_range(1, 3)), 8'($urandom_range(0, 255))});
         if ((stim_mul_q.size() == 0) && ($urandom_range(0, 3) != 0))
            stim_mul_q.push_back({4'($urandom_range(4, 6)), 8'($urandom_range(0, 255))});
         step();
      end
      drain(40);
      check("rand_no_tag_err", 32'(tag_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
